pipe_hazard_unit: RTL

- Parametrised hazard/forwarding controller for the pipelined MIPS core. It succeeds the original core, which had no interlocks.
- Holds a scoreboard of in-flight register writes for the DEPTH stages after ID. From it the block drives operand-forward selects, load-use stalls, and wrong-path kill signals when a branch or jump redirects the PC.
- Sits beside the ID stage. The datapath uses its outputs to steer forward muxes, hold PC and IF/ID, and bubble pipeline registers.

---
 rtl/pipe_hazard_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the pipelined MIPS core: tracks in-flight register writes
// after ID and produces forward selects, load-use stalls and wrong-path kills on redirect.
module pipe_hazard_unit #(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned LOAD_READY     = 2,
  parameter int unsigned REDIRECT_STAGE = 2,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned SEL_W         = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_regwr_i,
  input  logic              id_memtoreg_i,
  input  logic [REG_AW-1:0] id_wraddr_i,
  input  logic              redirect_i,
  output logic              stall_o,
  output logic              kill_id_o,
  output logic [DEPTH-1:0]  kill_mask_o,
  output logic [SEL_W-1:0]  fwd_a_sel_o,
  output logic [SEL_W-1:0]  fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_count_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  // Scoreboard entries, index k = stage k after ID.
  logic [DEPTH:1]    vld_q, vld_d;
  logic [DEPTH:1]    wr_q, wr_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [REG_AW-1:0] addr_q [1:DEPTH];
  logic [REG_AW-1:0] addr_d [1:DEPTH];

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              lu_a, lu_b;
  logic              stall;

  // Walk from oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_a_sel_o = '0;
    fwd_b_sel_o = '0;
    lu_a        = 1'b0;
    lu_b        = 1'b0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (id_use_rs_i && vld_q[k] && wr_q[k] && (addr_q[k] == id_rs_i) && (id_rs_i != '0)) begin
        fwd_a_sel_o = SEL_W'(k);
        lu_a        = ld_q[k] && (k < int'(LOAD_READY));
      end
      if (id_use_rt_i && vld_q[k] && wr_q[k] && (addr_q[k] == id_rt_i) && (id_rt_i != '0)) begin
        fwd_b_sel_o = SEL_W'(k);
        lu_b        = ld_q[k] && (k < int'(LOAD_READY));
      end
    end
  end

  assign stall     = id_valid_i && (lu_a || lu_b) && !redirect_i;
  assign stall_o   = stall;
  assign kill_id_o = redirect_i;

  always_comb begin
    kill_mask_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      kill_mask_o[k] = redirect_i && ((k + 2) <= int'(REDIRECT_STAGE));
    end
  end

  // Shift one stage per edge; stages younger than the redirecting branch are squashed.
  always_comb begin
    vld_d     = '0;
    wr_d      = '0;
    ld_d      = '0;
    for (int k = int'(DEPTH); k >= 2; k--) begin
      vld_d[k]  = vld_q[k-1] && !(redirect_i && (k <= int'(REDIRECT_STAGE)));
      wr_d[k]   = wr_q[k-1];
      ld_d[k]   = ld_q[k-1];
      addr_d[k] = addr_q[k-1];
    end
    vld_d[1]  = id_valid_i && !stall && !redirect_i;
    wr_d[1]   = id_regwr_i;
    ld_d[1]   = id_memtoreg_i;
    addr_d[1] = id_wraddr_i;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int k = 1; k <= int'(DEPTH); k++) begin
        addr_q[k] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 1; k <= int'(DEPTH); k++) begin
        addr_q[k] <= addr_d[k];
      end
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
